// File: rtl/alu_mc.sv
// alu_mc: multi-cycle EX-stage ALU with valid/ready handshakes.
// Ops: AND/OR/ADD/SUB/SLT in one cycle; MUL/DIVU/REMU iterate one bit per cycle.
// Ports:
//   clk, rst (sync, active-high)
//   in_valid/in_ready, op[2:0], src_a, src_b : operand side
//   out_valid/out_ready, result, div_by_zero  : result side
//   zero_flag : only when ALU_ZERO_FLAG_EN is defined
module alu_mc #(
    parameter int WIDTH      = 32,
    parameter int SLT_SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
`ifdef ALU_ZERO_FLAG_EN
    ,
    output logic             zero_flag
`endif
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_DIVU = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_SLT  = 3'b110;
    localparam logic [2:0] OP_REMU = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    // MUL: x = multiplier, y = multiplicand, acc = partial product.
    // DIV: x = dividend shifting into quotient, y = divisor, acc = remainder.
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_d;
    logic             dbz_d;

    logic             lt;
    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             ge;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] quo_n;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);

    always_comb begin
        if (SLT_SIGNED != 0) begin
            lt = $signed(src_a) < $signed(src_b);
        end else begin
            lt = src_a < src_b;
        end
    end

    // One restoring-division step; trial sign bit says whether
    // the divisor fits into the shifted partial remainder.
    assign mul_acc = x_q[0] ? (acc_q + y_q) : acc_q;
    assign shifted = {acc_q, x_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, y_q};
    assign ge      = ~trial[WIDTH];
    assign rem_n   = ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_n   = {x_q[WIDTH-2:0], ge};

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        x_d      = x_q;
        y_d      = y_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result;
        dbz_d    = div_by_zero;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d  = op;
                    acc_d = '0;
                    cnt_d = CW'(WIDTH - 1);
                    dbz_d = 1'b0;
                    unique case (op)
                        OP_AND: begin
                            result_d = src_a & src_b;
                            state_d  = DONE;
                        end
                        OP_OR: begin
                            result_d = src_a | src_b;
                            state_d  = DONE;
                        end
                        OP_ADD: begin
                            result_d = src_a + src_b;
                            state_d  = DONE;
                        end
                        OP_SUB: begin
                            result_d = src_a - src_b;
                            state_d  = DONE;
                        end
                        OP_SLT: begin
                            result_d = {{(WIDTH-1){1'b0}}, lt};
                            state_d  = DONE;
                        end
                        OP_MUL: begin
                            x_d     = src_b;
                            y_d     = src_a;
                            state_d = CALC;
                        end
                        OP_DIVU, OP_REMU: begin
                            if (src_b == '0) begin
                                result_d = (op == OP_DIVU) ? '1 : src_a;
                                dbz_d    = 1'b1;
                                state_d  = DONE;
                            end else begin
                                x_d     = src_a;
                                y_d     = src_b;
                                state_d = CALC;
                            end
                        end
                    endcase
                end
            end
            CALC: begin
                cnt_d = cnt_q - 1'b1;
                if (op_q == OP_MUL) begin
                    acc_d = mul_acc;
                    x_d   = x_q >> 1;
                    y_d   = y_q << 1;
                end else begin
                    acc_d = rem_n;
                    x_d   = quo_n;
                end
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    if (op_q == OP_MUL) begin
                        result_d = mul_acc;
                    end else if (op_q == OP_DIVU) begin
                        result_d = quo_n;
                    end else begin
                        result_d = rem_n;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    dbz_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            x_q         <= '0;
            y_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            result      <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            x_q         <= x_d;
            y_q         <= y_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            result      <= result_d;
            div_by_zero <= dbz_d;
        end
    end

`ifdef ALU_ZERO_FLAG_EN
    // Follows result into DONE and drops as soon as DONE is left.
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_flag <= 1'b0;
        end else begin
            zero_flag <= (state_d == DONE) && (result_d == '0);
        end
    end
`endif

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed checks for alu_mc (WIDTH=32).
// A second instance with SLT_SIGNED=1 shares the stimulus.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        dbz;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [31:0] s_result;
    logic        s_dbz;

`ifdef ALU_ZERO_FLAG_EN
    logic        zf;
    logic        s_zf;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(32), .SLT_SIGNED(0)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .op(op),
        .src_a(src_a),
        .src_b(src_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .div_by_zero(dbz)
`ifdef ALU_ZERO_FLAG_EN
        ,
        .zero_flag(zf)
`endif
    );

    alu_mc #(.WIDTH(32), .SLT_SIGNED(1)) dut_s (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(s_in_ready),
        .op(op),
        .src_a(src_a),
        .src_b(src_b),
        .out_valid(s_out_valid),
        .out_ready(out_ready),
        .result(s_result),
        .div_by_zero(s_dbz)
`ifdef ALU_ZERO_FLAG_EN
        ,
        .zero_flag(s_zf)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op, scramble inputs after accept, wait for the
    // result, check it, then drain with a single out_ready pulse.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_dbz,
                          input int exp_lat);
        int lat;
        logic busy_ok;
        op       = o;
        src_a    = a;
        src_b    = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        op       = 3'b111;
        src_a    = 32'hdead_beef;
        src_b    = 32'h0000_0000;
        lat      = 1;
        busy_ok  = 1'b1;
        while (!out_valid && lat < 200) begin
            if (in_ready) busy_ok = 1'b0;
            tick();
            lat++;
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " result"}, result, exp_res);
        chk({tag, " dbz"}, {31'b0, dbz}, {31'b0, exp_dbz});
        chk({tag, " busy"}, {31'b0, busy_ok & ~in_ready}, 32'd1);
`ifdef ALU_ZERO_FLAG_EN
        chk({tag, " zf"}, {31'b0, zf}, {31'b0, exp_res == 32'd0});
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, " drain"}, {30'b0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        op        = 3'b000;
        src_a     = '0;
        src_b     = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset dbz", {31'b0, dbz}, 32'd0);

        run_op("add wrap", 3'b010, 32'hffff_ffff, 32'h2, 32'h1, 1'b0, 1);
        run_op("mul", 3'b101, 32'h0001_0001, 32'h0001_0001,
               32'h0002_0001, 1'b0, 33);
        run_op("divu", 3'b011, 32'd100, 32'd7, 32'd14, 1'b0, 33);
        run_op("remu", 3'b111, 32'd100, 32'd7, 32'd2, 1'b0, 33);
        run_op("divu by 0", 3'b011, 32'd5, 32'd0, 32'hffff_ffff, 1'b1, 1);
        run_op("add clr dbz", 3'b010, 32'd3, 32'd4, 32'd7, 1'b0, 1);
        run_op("remu by 0", 3'b111, 32'd5, 32'd0, 32'd5, 1'b1, 1);
        run_op("sub", 3'b100, 32'd5, 32'd7, 32'hffff_fffe, 1'b0, 1);
        run_op("and", 3'b000, 32'hf0f0, 32'hff00, 32'hf000, 1'b0, 1);
        run_op("or", 3'b001, 32'hf0f0, 32'hff00, 32'hfff0, 1'b0, 1);
        run_op("sub zero", 3'b100, 32'h1234, 32'h1234, 32'h0, 1'b0, 1);
        run_op("mul max", 3'b101, 32'hffff_ffff, 32'hffff_ffff,
               32'h1, 1'b0, 33);
        run_op("divu big", 3'b011, 32'hffff_ffff, 32'h10,
               32'h0fff_ffff, 1'b0, 33);
        run_op("remu big", 3'b111, 32'hffff_ffff, 32'h10,
               32'hf, 1'b0, 33);

        // SLT: both instances see the same op.
        op       = 3'b110;
        src_a    = 32'hffff_ffff;
        src_b    = 32'h1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("slt u valid", {31'b0, out_valid}, 32'd1);
        chk("slt u result", result, 32'd0);
        chk("slt s valid", {31'b0, s_out_valid}, 32'd1);
        chk("slt s result", s_result, 32'd1);
        chk("slt s side", {30'b0, s_in_ready, s_dbz}, 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("slt drain", {30'b0, out_valid, in_ready}, 32'd1);

        // Backpressure, then a new op offered on the draining edge.
        op       = 3'b101;
        src_a    = 32'd3;
        src_b    = 32'd5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        seen     = 1;
        while (!out_valid && seen < 200) begin
            tick();
            seen++;
        end
        chk("bp latency", seen, 32'd33);
        for (int i = 0; i < 5; i++) begin
            chk("bp result", result, 32'd15);
            chk("bp hold", {30'b0, out_valid, in_ready}, 32'd2);
            tick();
        end
        op        = 3'b010;
        src_a     = 32'd1;
        src_b     = 32'd1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("no bypass", {30'b0, out_valid, in_ready}, 32'd1);
        chk("no bypass result", result, 32'd15);
        tick();
        in_valid = 1'b0;
        chk("ii2 valid", {31'b0, out_valid}, 32'd1);
        chk("ii2 result", result, 32'd2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset during MUL iteration.
        op       = 3'b101;
        src_a    = 32'd9;
        src_b    = 32'd9;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort in_ready", {31'b0, in_ready}, 32'd1);
        chk("abort result", result, 32'd0);
        chk("abort out_valid", {31'b0, out_valid}, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            tick();
        end
        chk("abort no result", seen, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
